main: RTL and testbench
=======================

# main

Self-contained linear-regression engine: holds a fixed table of N (x, y) sample pairs and computes the least-squares slope and intercept on request. Results are signed Q16.8 fixed-point values kept in internal registers. The only external output is a completion strobe, so this is the top level of the FPGA regression demo. Verification reads the result registers hierarchically.

## Interface
- N, 8: number of sample pairs; fixed at 8.
- W, 8: width of each unsigned sample.
- XDATA, {8'd8,8'd7,8'd6,8'd5,8'd4,8'd3,8'd2,8'd1}: packed x samples; sample i is XDATA[W*i +: W].
- YDATA, {8'd19,8'd17,8'd15,8'd13,8'd11,8'd9,8'd7,8'd5}: packed y samples, same packing.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  run request, sampled on the rising edge.
- strb  output  1  result-valid strobe; registered.
- Internal registers with fixed names, read hierarchically by verification:
  - slope: signed 24 bits, Q16.8.
  - intercept: signed 24 bits, Q16.8.

## Operation
- States:
  - IDLE: waits for start.
  - ACCUM: 8 cycles, one sample pair per cycle.
  - CALC: 1 cycle.
  - DIV_M: 33 cycles.
  - CALC_B: 1 cycle.
  - DIV_B: 33 cycles.
  - DONE: holds until restarted or reset.
- IDLE or DONE with start=1: clear the sums, strb and the sample index, then go to ACCUM.
- ACCUM: accumulate Sx=Σx, Sy=Σy, Sxy=Σx·y and Sxx=Σx², all unsigned.
  - Sx and Sy: 11 bits each.
  - Sxy and Sxx: 20 bits each.
- CALC:
  - num = N·Sxy − Sx·Sy, signed 25 bits.
  - den = N·Sxx − Sx², signed 25 bits.
  - Dividend = num<<8.
- DIV_M: slope = dividend/den.
  - 32-iteration restoring division on magnitudes, plus 1 sign-fix cycle.
  - Quotient truncates toward zero; result keeps the low 24 bits.
  - den=0 (all x equal): slope=0.
- CALC_B: dividend = (Sy<<8) − slope·Sx, signed.
- DIV_B: intercept = dividend/N.
  - Same divider, same truncation toward zero.
- DONE: strb=1.
- start is ignored in ACCUM, CALC, DIV_M, CALC_B and DIV_B.
- start=1 in DONE restarts the run: strb drops on that edge.

## Timing
- Reset values (async, reset=0):
  - State IDLE.
  - strb=0.
  - slope=0, intercept=0.
  - All sums 0, sample index 0.
- Reset asserted mid-run aborts the run immediately. No partial result is retained.
- Edges are counted from the sampling edge E0, the edge that accepts start:
  - E1..E8: accumulate samples 0..7.
  - E9: CALC.
  - E10..E42: DIV_M. slope is valid after E42.
  - E43: CALC_B.
  - E44..E76: DIV_B.
  - E76: state becomes DONE and strb goes high. intercept is valid from the same edge.
- Total latency from the start sampling edge to strb high: exactly 76 cycles.
- strb remains high until a restart or reset; it is a level, not a pulse.
- start held high across several edges in IDLE triggers only one run. Later edges fall in busy states and are ignored.
- The design holds no combinational path from start to strb.

## Test plan
- Reset check: hold reset=0 with clk running -> strb=0, slope=0, intercept=0, state IDLE.
- Default data, start pulsed for one edge:
  - strb rises exactly 76 edges later.
  - slope=24'h000200 (2.0), intercept=24'h000300 (3.0).
- Negative slope, YDATA = y=19..12 for x=1..8 -> slope=24'hFFFF00 (−1.0), intercept=24'h001400 (20.0).
- Fractional result, YDATA y={1,1,2,2,3,3,4,4}, x=1..8:
  - Intermediate values: num=160, den=336.
  - slope=24'h000079 (121).
  - intercept=24'h00005F (95, since 764/8 truncates to 95).
- Degenerate denominator, all x=5 and y=1..8 -> slope=0, intercept=24'h000480 (4.5).
- Control:
  - start pulsed again during DIV_M -> run completes at the original edge 76.
  - reset asserted at edge 30 -> strb stays 0 and a fresh start yields correct results.
  - start in DONE -> strb drops, then rises 76 edges later with the same values.

Source files
------------

// File: rtl/main.sv
// Least-squares line fit over a fixed table of N (x, y) samples; slope and intercept in signed Q16.8.
// Latency: strb rises exactly 76 clk edges after the edge that accepts start.
// start is only honoured in IDLE or DONE; busy states ignore it, strb is a level held until restart/reset.
module main #(
    parameter int             N     = 8,
    parameter int             W     = 8,
    parameter logic [N*W-1:0] XDATA = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
    parameter logic [N*W-1:0] YDATA = {8'd19, 8'd17, 8'd15, 8'd13, 8'd11, 8'd9, 8'd7, 8'd5}
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic strb
);

    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        CALC   = 3'd2,
        DIV_M  = 3'd3,
        CALC_B = 3'd4,
        DIV_B  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t state;
    state_t state_n;

    // Running sums and sample pointer
    logic [IW-1:0] idx;
    logic [10:0]   sx;
    logic [10:0]   sy;
    logic [19:0]   sxy;
    logic [19:0]   sxx;

    // Results, read hierarchically
    logic signed [23:0] slope;
    logic signed [23:0] intercept;

    // Shared restoring divider: quo starts as the dividend magnitude and is
    // shifted out into rem while quotient bits are shifted in from the right.
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic        q_neg;
    logic        den_zero;
    logic [5:0]  cnt;

    // Current sample pair
    logic [W-1:0] x_cur;
    logic [W-1:0] y_cur;
    assign x_cur = XDATA[W*idx +: W];
    assign y_cur = YDATA[W*idx +: W];

    // Slope numerator and denominator, straight from the sums (held stable in CALC and after)
    logic [24:0] num_c;
    logic [24:0] den_c;
    logic [24:0] num_abs;
    logic [24:0] den_abs;
    assign num_c   = 25'(N) * {5'd0, sxy} - {14'd0, sx} * {14'd0, sy};
    assign den_c   = 25'(N) * {5'd0, sxx} - {14'd0, sx} * {14'd0, sx};
    assign num_abs = num_c[24] ? (25'd0 - num_c) : num_c;
    assign den_abs = den_c[24] ? (25'd0 - den_c) : den_c;

    // Intercept dividend: (Sy<<8) - slope*Sx, all signed Q16.8 scaled
    logic signed [39:0] b_prod;
    logic signed [39:0] b_dvd;
    logic        [39:0] b_abs;
    assign b_prod = 40'(slope) * 40'($signed({1'b0, sx}));
    assign b_dvd  = $signed({21'd0, sy, 8'd0}) - b_prod;
    assign b_abs  = b_dvd[39] ? 40'(-b_dvd) : 40'(b_dvd);

    // One restoring-division step and the signed, truncated-toward-zero result
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_nx;
    logic [31:0] quo_s;
    assign rem_sh = {rem, quo[31]};
    assign rem_ge = rem_sh >= {1'b0, dvs};
    assign rem_nx = rem_ge ? 32'(rem_sh - {1'b0, dvs}) : rem_sh[31:0];
    assign quo_s  = q_neg ? (32'd0 - quo) : quo;

    // Bits that are provably zero or deliberately discarded by the 24-bit result format
    logic unused_bits;
    assign unused_bits = ^{num_abs[24], b_abs[39:32], quo_s[31:24]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state sequencing
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = ACCUM;
            ACCUM:   if (idx == IW'(N - 1)) state_n = CALC;
            CALC:    state_n = DIV_M;
            DIV_M:   if (cnt == 6'd32) state_n = CALC_B;
            CALC_B:  state_n = DIV_B;
            DIV_B:   if (cnt == 6'd32) state_n = DONE;
            DONE:    if (start) state_n = ACCUM;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: accumulation, divider loading/stepping, result and strobe registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            sx        <= '0;
            sy        <= '0;
            sxy       <= '0;
            sxx       <= '0;
            slope     <= '0;
            intercept <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            q_neg     <= 1'b0;
            den_zero  <= 1'b0;
            cnt       <= '0;
            strb      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx  <= '0;
                        sx   <= '0;
                        sy   <= '0;
                        sxy  <= '0;
                        sxx  <= '0;
                        strb <= 1'b0;
                    end
                end
                ACCUM: begin
                    sx  <= sx + 11'(x_cur);
                    sy  <= sy + 11'(y_cur);
                    sxy <= sxy + 20'(x_cur) * 20'(y_cur);
                    sxx <= sxx + 20'(x_cur) * 20'(x_cur);
                    idx <= idx + 1'b1;
                end
                CALC: begin
                    quo      <= {num_abs[23:0], 8'd0};
                    rem      <= '0;
                    dvs      <= {7'd0, den_abs};
                    q_neg    <= num_c[24] ^ den_c[24];
                    den_zero <= (den_c == 25'd0);
                    cnt      <= '0;
                end
                DIV_M: begin
                    if (cnt != 6'd32) begin
                        rem <= rem_nx;
                        quo <= {quo[30:0], rem_ge};
                        cnt <= cnt + 1'b1;
                    end else begin
                        slope <= den_zero ? 24'sd0 : $signed(quo_s[23:0]);
                    end
                end
                CALC_B: begin
                    quo   <= b_abs[31:0];
                    rem   <= '0;
                    dvs   <= 32'(N);
                    q_neg <= b_dvd[39];
                    cnt   <= '0;
                end
                DIV_B: begin
                    if (cnt != 6'd32) begin
                        rem <= rem_nx;
                        quo <= {quo[30:0], rem_ge};
                        cnt <= cnt + 1'b1;
                    end else begin
                        intercept <= $signed(quo_s[23:0]);
                        strb      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_main.sv
// Bench for main: four instances with different sample tables share clk/reset/start.
// Stimulus pushes the expected completion edge and results; a monitor checks on each strb rise.
// Control cases: retrigger while busy, mid-run reset abort, restart from DONE.
module tb_main;

    logic clk;
    logic reset;
    logic start;
    logic strb_w [4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [31:0] due;
        logic [95:0] sl;
        logic [95:0] ic;
    } exp_t;

    exp_t exp_q [$];

    // Expected results for the four tables: default, negative, fractional, degenerate
    localparam logic [95:0] EXP_SL = {24'h000000, 24'h000079, 24'hFFFF00, 24'h000200};
    localparam logic [95:0] EXP_IC = {24'h000480, 24'h00005F, 24'h001400, 24'h000300};

    main u_def (.clk(clk), .reset(reset), .start(start), .strb(strb_w[0]));

    main #(.YDATA({8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19}))
        u_neg (.clk(clk), .reset(reset), .start(start), .strb(strb_w[1]));

    main #(.YDATA({8'd4, 8'd4, 8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1}))
        u_frac (.clk(clk), .reset(reset), .start(start), .strb(strb_w[2]));

    main #(.XDATA({8{8'd5}}),
           .YDATA({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}))
        u_deg (.clk(clk), .reset(reset), .start(start), .strb(strb_w[3]));

    logic [23:0] sl [4];
    logic [23:0] ic [4];
    assign sl[0] = u_def.slope;
    assign sl[1] = u_neg.slope;
    assign sl[2] = u_frac.slope;
    assign sl[3] = u_deg.slope;
    assign ic[0] = u_def.intercept;
    assign ic[1] = u_neg.intercept;
    assign ic[2] = u_frac.intercept;
    assign ic[3] = u_deg.intercept;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Drive start for 'hold' edges; E0 is the first of them. strb must be low right after E0.
    task automatic do_start(input int hold, input bit expect_run);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (expect_run) begin
            e.due = 32'(cyc + 76);
            e.sl  = EXP_SL;
            e.ic  = EXP_IC;
            exp_q.push_back(e);
        end
        chk("strb_low_after_start", 32'(strb_w[0]), 32'd0);
        for (int i = 1; i < hold; i++) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        chk("completion_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
    endtask

    // Monitor: on each strb rise pop the oldest expectation and compare everything
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (strb_w[0] && !prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strb", 32'(strb_w[0]), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency_edge", 32'(cyc), e.due);
                    for (int k = 0; k < 4; k++) begin
                        chk($sformatf("strb[%0d]", k), 32'(strb_w[k]), 32'd1);
                        chk($sformatf("slope[%0d]", k), 32'(sl[k]), 32'(e.sl[24*k +: 24]));
                        chk($sformatf("intercept[%0d]", k), 32'(ic[k]), 32'(e.ic[24*k +: 24]));
                    end
                    chk("frac_num", 32'(u_frac.num_c), 32'd160);
                    chk("frac_den", 32'(u_frac.den_c), 32'd336);
                end
            end
            prev = strb_w[0];
        end
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;

        // Reset state with the clock running
        repeat (4) @(posedge clk);
        #1;
        chk("rst_strb", 32'(strb_w[0]), 32'd0);
        chk("rst_slope", 32'(sl[0]), 32'd0);
        chk("rst_intercept", 32'(ic[0]), 32'd0);
        chk("rst_state", 32'(u_def.state), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Plain run
        do_start(1, 1'b1);
        wait_idle();
        chk("strb_level_held", 32'(strb_w[0]), 32'd1);

        // Restart from DONE, then poke start while the slope divider is busy
        do_start(1, 1'b1);
        repeat (18) @(posedge clk);
        chk("busy_in_div_m", 32'(u_def.state), 32'd3);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Abort with reset at edge 30 of a run
        do_start(1, 1'b0);
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_strb", 32'(strb_w[0]), 32'd0);
        chk("abort_slope", 32'(sl[0]), 32'd0);
        chk("abort_intercept", 32'(ic[0]), 32'd0);
        chk("abort_state", 32'(u_def.state), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (90) @(posedge clk);
        #1;
        chk("no_strb_after_abort", 32'(strb_w[0]), 32'd0);

        // Fresh run with start held high for three edges: only one run
        do_start(3, 1'b1);
        wait_idle();

        // Restart from DONE gives the same values again
        do_start(1, 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
